// File: rtl/cs_video_pkg.sv
// Shared timing defaults and layer bundle for the Computer Space video path.
// The layer struct is also used by the emu-level colour/invert mixer.
package cs_video_pkg;

  localparam int CE_DIV_DEF       = 4;
  localparam int H_ACTIVE_DEF     = 260;
  localparam int H_TOTAL_DEF      = 320;
  localparam int H_SYNC_START_DEF = 276;
  localparam int H_SYNC_LEN_DEF   = 24;
  localparam int V_ACTIVE_DEF     = 240;
  localparam int V_TOTAL_DEF      = 262;
  localparam int V_SYNC_START_DEF = 248;
  localparam int V_SYNC_LEN_DEF   = 3;

  typedef struct packed {
    logic invert;
    logic saucer;
    logic craft;
    logic star;
  } layers_t;

  function automatic logic in_window(input int unsigned val, input int unsigned start,
                                     input int unsigned len);
    return (val >= start) && (val < start + len);
  endfunction

endpackage

// File: rtl/cs_sync_window.sv
// Wrapping raster counter with blank/sync window decode for one axis.
// SYNC_ON_NEXT decodes sync from the post-advance count so sync edges land on count changes.
module cs_sync_window
  import cs_video_pkg::*;
#(
  parameter int TOTAL        = H_TOTAL_DEF,
  parameter int ACTIVE       = H_ACTIVE_DEF,
  parameter int SYNC_START   = H_SYNC_START_DEF,
  parameter int SYNC_LEN     = H_SYNC_LEN_DEF,
  parameter bit SYNC_ON_NEXT = 1'b0,
  parameter int W            = $clog2(TOTAL)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         advance,
  output logic [W-1:0] count,
  output logic         wrap,
  output logic         blank,
  output logic         sync
);

  logic [W-1:0] count_q, count_d, count_nx;

  always_comb begin
    wrap     = (count_q == W'(TOTAL - 1));
    count_nx = wrap ? '0 : count_q + 1'b1;
    count_d  = advance ? count_nx : count_q;
    blank    = (count_q >= W'(ACTIVE));
    sync     = in_window(SYNC_ON_NEXT ? 32'(count_nx) : 32'(count_q), SYNC_START, SYNC_LEN);
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/cs_video_timing.sv
// Raster timing source: pixel enable divider, H/V counters, registered sync/blank
// and blank-gated layer bits, plus a one-cycle frame_start at the (0,0) return.
module cs_video_timing
  import cs_video_pkg::*;
#(
  parameter int CE_DIV       = CE_DIV_DEF,
  parameter int H_ACTIVE     = H_ACTIVE_DEF,
  parameter int H_TOTAL      = H_TOTAL_DEF,
  parameter int H_SYNC_START = H_SYNC_START_DEF,
  parameter int H_SYNC_LEN   = H_SYNC_LEN_DEF,
  parameter int V_ACTIVE     = V_ACTIVE_DEF,
  parameter int V_TOTAL      = V_TOTAL_DEF,
  parameter int V_SYNC_START = V_SYNC_START_DEF,
  parameter int V_SYNC_LEN   = V_SYNC_LEN_DEF,
  parameter int HW           = $clog2(H_TOTAL),
  parameter int VW           = $clog2(V_TOTAL)
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic [3:0]    layers_in,
  output logic          ce_pix,
  output logic [HW-1:0] hcount,
  output logic [VW-1:0] vcount,
  output logic          hsync,
  output logic          vsync,
  output logic          hblank,
  output logic          vblank,
  output logic [3:0]    video,
  output logic          frame_start
);

  localparam int DW = $clog2(CE_DIV);

  if (H_ACTIVE > H_SYNC_START) begin : g_bad_h_active
    $fatal(1, "cs_video_timing: H_ACTIVE must not exceed H_SYNC_START");
  end
  if (H_SYNC_START + H_SYNC_LEN > H_TOTAL) begin : g_bad_h_sync
    $fatal(1, "cs_video_timing: hsync window runs past H_TOTAL");
  end
  if (V_ACTIVE > V_SYNC_START) begin : g_bad_v_active
    $fatal(1, "cs_video_timing: V_ACTIVE must not exceed V_SYNC_START");
  end
  if (V_SYNC_START + V_SYNC_LEN > V_TOTAL) begin : g_bad_v_sync
    $fatal(1, "cs_video_timing: vsync window runs past V_TOTAL");
  end
  if (CE_DIV < 2) begin : g_bad_ce_div
    $fatal(1, "cs_video_timing: CE_DIV must be at least 2");
  end

  logic [DW-1:0] div_q, div_d;
  logic          ce_pix_q, ce_pix_d;
  logic          hsync_q, hsync_d, vsync_q, vsync_d;
  logic          hblank_q, hblank_d, vblank_q, vblank_d;
  logic          frame_start_q, frame_start_d;
  layers_t       video_q, video_d;

  logic h_wrap, h_blank, h_sync;
  logic v_wrap, v_blank, v_sync_next;

  cs_sync_window #(
    .TOTAL(H_TOTAL), .ACTIVE(H_ACTIVE), .SYNC_START(H_SYNC_START), .SYNC_LEN(H_SYNC_LEN),
    .SYNC_ON_NEXT(1'b0), .W(HW)
  ) u_h (
    .clk(clk_sys), .reset(reset), .advance(ce_pix_q),
    .count(hcount), .wrap(h_wrap), .blank(h_blank), .sync(h_sync)
  );

  // vsync looks at the line being entered so its edges coincide with vcount changes.
  cs_sync_window #(
    .TOTAL(V_TOTAL), .ACTIVE(V_ACTIVE), .SYNC_START(V_SYNC_START), .SYNC_LEN(V_SYNC_LEN),
    .SYNC_ON_NEXT(1'b1), .W(VW)
  ) u_v (
    .clk(clk_sys), .reset(reset), .advance(ce_pix_q & h_wrap),
    .count(vcount), .wrap(v_wrap), .blank(v_blank), .sync(v_sync_next)
  );

  always_comb begin
    div_d         = (div_q == DW'(CE_DIV - 1)) ? '0 : div_q + 1'b1;
    ce_pix_d      = (div_q == '0);
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    hblank_d      = hblank_q;
    vblank_d      = vblank_q;
    video_d       = video_q;
    // Counters are frozen while ce_pix_d is being set up, so this lines up with that ce_pix.
    frame_start_d = ce_pix_d & h_wrap & v_wrap;
    if (ce_pix_q) begin
      hsync_d  = h_sync;
      hblank_d = h_blank;
      vblank_d = v_blank;
      video_d  = (h_blank | v_blank) ? '0 : layers_t'(layers_in);
      if (h_wrap) vsync_d = v_sync_next;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      div_q         <= '0;
      ce_pix_q      <= 1'b0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      hblank_q      <= 1'b0;
      vblank_q      <= 1'b0;
      video_q       <= '0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      ce_pix_q      <= ce_pix_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      hblank_q      <= hblank_d;
      vblank_q      <= vblank_d;
      video_q       <= video_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign ce_pix      = ce_pix_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign hblank      = hblank_q;
  assign vblank      = vblank_q;
  assign video       = video_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_cs_video_timing.sv
// Bench for cs_video_timing on a shrunken raster so several frames fit in a short run.
// Expected outputs come from a pixel-index model: pixel n maps to (n % H_TOTAL, n / H_TOTAL).
module tb_cs_video_timing;

  localparam int CE_DIV = 3;
  localparam int HA = 20, HT = 32, HSS = 22, HSL = 4;
  localparam int VA = 12, VT = 16, VSS = 13, VSL = 2;
  localparam int HW = 5, VW = 4;
  localparam int FT = HT * VT;
  localparam int N_CYC = 6000;

  logic          clk_sys = 1'b0;
  logic          reset = 1'b1;
  logic [3:0]    layers_in = 4'd0;
  logic          ce_pix, hsync, vsync, hblank, vblank, frame_start;
  logic [HW-1:0] hcount;
  logic [VW-1:0] vcount;
  logic [3:0]    video;

  cs_video_timing #(
    .CE_DIV(CE_DIV),
    .H_ACTIVE(HA), .H_TOTAL(HT), .H_SYNC_START(HSS), .H_SYNC_LEN(HSL),
    .V_ACTIVE(VA), .V_TOTAL(VT), .V_SYNC_START(VSS), .V_SYNC_LEN(VSL)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .layers_in(layers_in),
    .ce_pix(ce_pix), .hcount(hcount), .vcount(vcount),
    .hsync(hsync), .vsync(vsync), .hblank(hblank), .vblank(vblank),
    .video(video), .frame_start(frame_start)
  );

  always #5 clk_sys = ~clk_sys;

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state: live = out of reset, n = current pixel index since release.
  bit         m_live = 1'b0;
  bit         m_ce = 1'b0;
  bit         m_have_prev = 1'b0;
  int         m_cyc = 0;
  int         m_n = 0;
  int         m_prev = 0;
  logic [3:0] m_lay = 4'd0;

  task automatic step_model();
    if (reset) begin
      m_live = 1'b0; m_ce = 1'b0; m_have_prev = 1'b0; m_n = 0;
    end else if (!m_live) begin
      m_live = 1'b1; m_cyc = 0; m_ce = 1'b1; m_n = 0; m_have_prev = 1'b0;
    end else begin
      if (m_ce) begin
        m_prev = m_n; m_lay = layers_in; m_have_prev = 1'b1; m_n++;
      end
      m_cyc++;
      m_ce = (m_cyc % CE_DIV) == 0;
    end
  endtask

  task automatic check_all();
    int  h, v, ph, pv;
    bit  e_hb, e_vb, e_hs, e_vs, e_fs;
    logic [3:0] e_vid;
    h  = m_n % HT;
    v  = (m_n / HT) % VT;
    ph = m_prev % HT;
    pv = (m_prev / HT) % VT;
    e_hb  = m_have_prev && (ph >= HA);
    e_vb  = m_have_prev && (pv >= VA);
    e_hs  = m_have_prev && (ph >= HSS) && (ph < HSS + HSL);
    e_vs  = (v >= VSS) && (v < VSS + VSL);
    e_vid = (!m_have_prev || e_hb || e_vb) ? 4'd0 : m_lay;
    e_fs  = m_live && m_ce && ((m_n % FT) == FT - 1);
    check_eq("ce_pix", 32'(ce_pix), 32'(m_live && m_ce));
    check_eq("hcount", 32'(hcount), 32'(h));
    check_eq("vcount", 32'(vcount), 32'(v));
    check_eq("hblank", 32'(hblank), 32'(e_hb));
    check_eq("vblank", 32'(vblank), 32'(e_vb));
    check_eq("hsync", 32'(hsync), 32'(e_hs));
    check_eq("vsync", 32'(vsync), 32'(e_vs));
    check_eq("video", 32'(video), 32'(e_vid));
    check_eq("frame_start", 32'(frame_start), 32'(e_fs));
  endtask

  initial begin
    int rst_hold;
    rst_hold = 0;
    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      @(posedge clk_sys);
      #1;
      step_model();
      if (cyc < 4) begin
        reset = 1'b1;
      end else if (rst_hold > 0) begin
        rst_hold--;
        reset = 1'b1;
      end else if (cyc == 3100 || $urandom_range(0, 799) == 0) begin
        reset = 1'b1;
        rst_hold = $urandom_range(0, 2);
      end else begin
        reset = 1'b0;
      end
      // A constant pattern first, then a fresh random value every clock (mostly off-ce).
      layers_in = (cyc < 2000) ? 4'b1011 : 4'($urandom);
      @(negedge clk_sys);
      check_all();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
